// File: rtl/reorder_pkg.sv
// rtl/reorder_pkg.sv - shared widths and FSM encoding for the reorder trace dispatcher
package reorder_pkg;

    localparam int NUM_QUEUES_DEF = 4;
    localparam int DEPTH_DEF      = 8;
    localparam int MAX_UOPS_DEF   = 4;

    localparam int ID_WIDTH   = $clog2(DEPTH_DEF);
    localparam int SEL_WIDTH  = $clog2(NUM_QUEUES_DEF);
    localparam int UCNT_WIDTH = $clog2(MAX_UOPS_DEF) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } disp_state_e;

endpackage

// File: rtl/reorder_id_credit.sv
// rtl/reorder_id_credit.sv - ID allocation, outstanding-ID credits and optional commit order check
// Optional feature macro: REORDER_DISPATCH_ORDER_CHECK_EN
module reorder_id_credit
    import reorder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       accept_i,
    input  logic                       pull_i,
    input  logic [$clog2(DEPTH)-1:0]   commit_value_i,
    output logic [$clog2(DEPTH)-1:0]   next_id_o,
    output logic [$clog2(DEPTH):0]     credits_o,
    output logic                       can_accept_o,
    output logic                       order_err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0] next_id_q, next_id_d;
    logic [IW-1:0] exp_retire_q, exp_retire_d;
    logic [CW-1:0] outstanding_q, outstanding_d;

    always_comb begin
        next_id_d     = next_id_q;
        exp_retire_d  = exp_retire_q;
        outstanding_d = outstanding_q;
        if (accept_i) next_id_d = next_id_q + 1'b1;
        if (pull_i)   exp_retire_d = exp_retire_q + 1'b1;
        // Simultaneous accept and pull cancel out.
        case ({accept_i, pull_i})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_id_q     <= '0;
            exp_retire_q  <= '0;
            outstanding_q <= '0;
        end else begin
            next_id_q     <= next_id_d;
            exp_retire_q  <= exp_retire_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign next_id_o    = next_id_q;
    assign credits_o    = CW'(DEPTH) - outstanding_q;
    assign can_accept_o = (outstanding_q != CW'(DEPTH));

`ifdef REORDER_DISPATCH_ORDER_CHECK_EN
    logic order_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_err_q <= 1'b0;
        end else if (pull_i && (commit_value_i != exp_retire_q)) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err_o = order_err_q;
`else
    logic unused_exp_retire;
    assign unused_exp_retire = ^{exp_retire_q, commit_value_i};
    assign order_err_o       = 1'b0;
`endif

endmodule

// File: rtl/reorder_trace_dispatcher.sv
// rtl/reorder_trace_dispatcher.sv - sequences instruction micro-ops into the re-order trace interface
// Optional feature macro: REORDER_DISPATCH_ORDER_CHECK_EN (commit order check in reorder_id_credit)
module reorder_trace_dispatcher
    import reorder_pkg::*;
#(
    parameter int   NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int   DEPTH      = DEPTH_DEF,
    parameter int   MAX_UOPS   = MAX_UOPS_DEF,
    parameter logic BREAKPOINT = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     instr_valid_i,
    output logic                                     instr_ready_o,
    input  logic [$clog2(MAX_UOPS):0]                instr_uop_cnt_i,
    input  logic [MAX_UOPS*$clog2(NUM_QUEUES)-1:0]   instr_sels_i,
    output logic [$clog2(DEPTH)-1:0]                 instr_id_o,
    input  logic                                     rl_full_i,
    output logic                                     trace_push_o,
    output logic [$clog2(NUM_QUEUES)-1:0]            trace_sel_o,
    output logic                                     trace_break_o,
    output logic                                     trace_id_push_o,
    output logic [$clog2(DEPTH)-1:0]                 trace_id_value_o,
    input  logic                                     commit_id_valid_i,
    input  logic [$clog2(DEPTH)-1:0]                 commit_id_value_i,
    output logic                                     commit_id_pull_o,
    output logic                                     retire_valid_o,
    output logic [$clog2(DEPTH)-1:0]                 retire_id_o,
    output logic [$clog2(DEPTH):0]                   credits_o,
    output logic                                     busy_o,
    output logic                                     order_err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(NUM_QUEUES);
    localparam int UW = $clog2(MAX_UOPS) + 1;

    disp_state_e           state_q, state_d;
    logic [UW-1:0]         cnt_q, cnt_d;
    logic [UW-1:0]         idx_q, idx_d;
    logic [MAX_UOPS*SW-1:0] sels_q, sels_d;
    logic [IW-1:0]         cur_id_q, cur_id_d;
    logic                  retire_valid_q;
    logic [IW-1:0]         retire_id_q;

    logic                  accept;
    logic                  can_accept;
    logic [IW-1:0]         next_id;

    // Pull is suppressed while reset is held so every output reads idle.
    assign commit_id_pull_o = commit_id_valid_i & ~rst_i;

    reorder_id_credit #(.DEPTH(DEPTH)) u_id_credit (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .accept_i       (accept),
        .pull_i         (commit_id_pull_o),
        .commit_value_i (commit_id_value_i),
        .next_id_o      (next_id),
        .credits_o      (credits_o),
        .can_accept_o   (can_accept),
        .order_err_o    (order_err_o)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        sels_d           = sels_q;
        cur_id_d         = cur_id_q;
        accept           = 1'b0;
        instr_ready_o    = 1'b0;
        trace_push_o     = 1'b0;
        trace_sel_o      = '0;
        trace_break_o    = 1'b0;
        trace_id_push_o  = 1'b0;
        trace_id_value_o = '0;
        case (state_q)
            IDLE: begin
                instr_ready_o = can_accept;
                accept        = instr_valid_i & can_accept;
                if (accept) begin
                    cnt_d    = (instr_uop_cnt_i == '0) ? UW'(1) : instr_uop_cnt_i;
                    sels_d   = instr_sels_i;
                    cur_id_d = next_id;
                    idx_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!rl_full_i) begin
                    trace_push_o = 1'b1;
                    trace_sel_o  = sels_q[int'(idx_q)*SW +: SW];
                    if (idx_q == cnt_q - UW'(1)) begin
                        trace_break_o    = BREAKPOINT;
                        trace_id_push_o  = 1'b1;
                        trace_id_value_o = cur_id_q;
                        state_d          = IDLE;
                    end else begin
                        trace_break_o = ~BREAKPOINT;
                        idx_d         = idx_q + UW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            sels_q         <= '0;
            cur_id_q       <= '0;
            retire_valid_q <= 1'b0;
            retire_id_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            sels_q         <= sels_d;
            cur_id_q       <= cur_id_d;
            retire_valid_q <= commit_id_pull_o;
            retire_id_q    <= commit_id_value_i;
        end
    end

    assign instr_id_o     = next_id;
    assign retire_valid_o = retire_valid_q;
    assign retire_id_o    = retire_id_q;
    assign busy_o         = (state_q == ISSUE);

endmodule

// File: tb/tb_reorder_trace_dispatcher.sv
// tb/tb_reorder_trace_dispatcher.sv - directed self-checking bench for reorder_trace_dispatcher
module tb_reorder_trace_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_uop_cnt;
    logic [7:0] instr_sels;
    logic [2:0] instr_id;
    logic       rl_full;
    logic       trace_push;
    logic [1:0] trace_sel;
    logic       trace_break;
    logic       trace_id_push;
    logic [2:0] trace_id_value;
    logic       commit_valid;
    logic [2:0] commit_value;
    logic       commit_pull;
    logic       retire_valid;
    logic [2:0] retire_id;
    logic [3:0] credits;
    logic       busy;
    logic       order_err;

    int checks = 0;
    int errors = 0;

`ifdef REORDER_DISPATCH_ORDER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    reorder_trace_dispatcher dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_valid_i     (instr_valid),
        .instr_ready_o     (instr_ready),
        .instr_uop_cnt_i   (instr_uop_cnt),
        .instr_sels_i      (instr_sels),
        .instr_id_o        (instr_id),
        .rl_full_i         (rl_full),
        .trace_push_o      (trace_push),
        .trace_sel_o       (trace_sel),
        .trace_break_o     (trace_break),
        .trace_id_push_o   (trace_id_push),
        .trace_id_value_o  (trace_id_value),
        .commit_id_valid_i (commit_valid),
        .commit_id_value_i (commit_value),
        .commit_id_pull_o  (commit_pull),
        .retire_valid_o    (retire_valid),
        .retire_id_o       (retire_id),
        .credits_o         (credits),
        .busy_o            (busy),
        .order_err_o       (order_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        instr_valid  = 1'b0;
        commit_valid = 1'b0;
        rl_full      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready"},    instr_ready, 1);
        check({tag, " push"},     trace_push, 0);
        check({tag, " sel"},      trace_sel, 0);
        check({tag, " break"},    trace_break, 0);
        check({tag, " id_push"},  trace_id_push, 0);
        check({tag, " id_value"}, trace_id_value, 0);
        check({tag, " pull"},     commit_pull, 0);
        check({tag, " rvalid"},   retire_valid, 0);
        check({tag, " rid"},      retire_id, 0);
        check({tag, " credits"},  credits, 8);
        check({tag, " busy"},     busy, 0);
        check({tag, " oerr"},     order_err, 0);
        check({tag, " instr_id"}, instr_id, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] t1_sel [3];
        logic       t1_brk [3];
        t1_sel = '{2'd1, 2'd0, 2'd2};
        t1_brk = '{1'b0, 1'b0, 1'b1};

        rst = 1'b1; instr_valid = 0; instr_uop_cnt = 0; instr_sels = 0;
        rl_full = 0; commit_valid = 1; commit_value = 3'd5;
        repeat (2) @(negedge clk);
        #1 check_idle_outputs("rst");
        rst = 1'b0; commit_valid = 0;

        // Three-uop instruction, selectors {2,0,1}
        instr_valid = 1; instr_uop_cnt = 3; instr_sels = 8'b00_10_00_01;
        #1 check("t1 ready", instr_ready, 1);
        check("t1 id", instr_id, 0);
        @(negedge clk) instr_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("t1 push", trace_push, 1);
            check("t1 sel", trace_sel, t1_sel[k]);
            check("t1 break", trace_break, t1_brk[k]);
            check("t1 id_push", trace_id_push, (k == 2));
            if (k == 2) check("t1 id_value", trace_id_value, 0);
            check("t1 busy", busy, 1);
            check("t1 ready", instr_ready, 0);
            @(negedge clk);
        end
        #1 check("t1 done push", trace_push, 0);
        check("t1 done busy", busy, 0);

        // Two-uop instruction stalled by rl_full for five cycles
        instr_valid = 1; instr_uop_cnt = 2; instr_sels = 8'b0000_0111;
        #1 check("t2 id", instr_id, 1);
        @(negedge clk) instr_valid = 0; rl_full = 1;
        for (int k = 0; k < 5; k++) begin
            #1 check("t2 stall push", trace_push, 0);
            check("t2 stall id_push", trace_id_push, 0);
            check("t2 stall busy", busy, 1);
            @(negedge clk);
        end
        rl_full = 0;
        #1 check("t2 push0", trace_push, 1);
        check("t2 sel0", trace_sel, 3);
        check("t2 break0", trace_break, 0);
        check("t2 busy", busy, 1);
        @(negedge clk);
        #1 check("t2 push1", trace_push, 1);
        check("t2 sel1", trace_sel, 1);
        check("t2 break1", trace_break, 1);
        check("t2 id_push", trace_id_push, 1);
        check("t2 id_value", trace_id_value, 1);
        @(negedge clk);
        #1 check("t2 idle", busy, 0);
        check("t2 credits", credits, 6);

        // Exhaust all eight credits, then release one with a commit
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            instr_valid = 1; instr_uop_cnt = 1; instr_sels = 8'(i % 4);
            #1 check("t3 id", instr_id, i);
            check("t3 ready", instr_ready, 1);
            @(negedge clk) instr_valid = 0;
            #1 check("t3 push", trace_push, 1);
            check("t3 sel", trace_sel, i % 4);
            check("t3 id_push", trace_id_push, 1);
            check("t3 id_value", trace_id_value, i);
            @(negedge clk);
        end
        instr_valid = 1; instr_uop_cnt = 1; instr_sels = 8'd3;
        #1 check("t3 credits0", credits, 0);
        check("t3 blocked", instr_ready, 0);
        @(negedge clk);
        #1 check("t3 still blocked", instr_ready, 0);
        check("t3 not busy", busy, 0);
        commit_valid = 1; commit_value = 0;
        #1 check("t3 pull", commit_pull, 1);
        check("t3 ready in pull", instr_ready, 0);
        @(negedge clk) commit_valid = 0;
        #1 check("t3 rvalid", retire_valid, 1);
        check("t3 rid", retire_id, 0);
        check("t3 ready after", instr_ready, 1);
        check("t3 credits1", credits, 1);
        check("t3 id wrap", instr_id, 0);
        @(negedge clk) instr_valid = 0;
        #1 check("t3 accepted busy", busy, 1);
        check("t3 credits again 0", credits, 0);
        @(negedge clk);
        #1 check("t3 end busy", busy, 0);

        // Ten instructions, each committed in order; IDs and retires wrap
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1; instr_uop_cnt = 1; instr_sels = 8'd2;
            #1 check("t4 id", instr_id, i % 8);
            @(negedge clk) instr_valid = 0; commit_valid = 1; commit_value = 3'(i % 8);
            #1 check("t4 id_value", trace_id_value, i % 8);
            check("t4 pull", commit_pull, 1);
            @(negedge clk) commit_valid = 0;
            #1 check("t4 rvalid", retire_valid, 1);
            check("t4 rid", retire_id, i % 8);
        end
        @(negedge clk);
        #1 check("t4 rvalid off", retire_valid, 0);
        check("t4 oerr", order_err, 0);
        check("t4 credits", credits, 8);

        // Out-of-order commit: ID 1 while expecting 0
        reset_dut();
        instr_valid = 1; instr_uop_cnt = 1; instr_sels = 0;
        @(negedge clk) instr_valid = 0; commit_valid = 1; commit_value = 1;
        #1 check("t5 pull", commit_pull, 1);
        check("t5 oerr before", order_err, 0);
        @(negedge clk) commit_valid = 0;
        #1 check("t5 oerr", order_err, ERR_EXP);
        repeat (3) @(negedge clk);
        #1 check("t5 oerr held", order_err, ERR_EXP);
        rst = 1;
        @(negedge clk);
        #1 check("t5 oerr cleared", order_err, 0);
        rst = 0;

        // Reset during the second uop of a four-uop instruction
        @(negedge clk);
        instr_valid = 1; instr_uop_cnt = 4; instr_sels = 8'b11_10_01_00;
        @(negedge clk) instr_valid = 0;
        #1 check("t6 uop0 push", trace_push, 1);
        check("t6 uop0 sel", trace_sel, 0);
        @(negedge clk);
        #1 check("t6 uop1 push", trace_push, 1);
        check("t6 uop1 sel", trace_sel, 1);
        rst = 1;
        @(negedge clk);
        #1 check_idle_outputs("t6");
        rst = 0;
        @(negedge clk);
        instr_valid = 1; instr_uop_cnt = 1; instr_sels = 8'd2;
        #1 check("t6 id", instr_id, 0);
        check("t6 ready", instr_ready, 1);
        @(negedge clk) instr_valid = 0;
        #1 check("t6 push", trace_push, 1);
        check("t6 id_push", trace_id_push, 1);
        check("t6 id_value", trace_id_value, 0);
        check("t6 sel", trace_sel, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_trace_dispatcher.md
Name: reorder_trace_dispatcher

Overview:
Front-end scheduler for the re-order logic datapath. It accepts whole instructions (1..MAX_UOPS micro-ops, each tagged with a target queue) and allocates an in-order ID to each. It sequences the micro-ops one per cycle into the re-order logic trace interface, stalling while the re-order logic is full. It also drains the committed-ID queue, enforces an outstanding-ID credit limit of DEPTH, and reports retired IDs.

Parameters:
NUM_QUEUES, 4, number of execution queues being re-ordered
DEPTH, 8, re-order entries; power of 2; also the maximum number of outstanding IDs
MAX_UOPS, 4, maximum micro-ops per instruction
BREAKPOINT, 1'b1, trace_break_o value that marks the last micro-op

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
instr_valid_i  in  1  instruction request
instr_ready_o  out  1  dispatcher can accept an instruction
instr_uop_cnt_i  in  UCNT_WIDTH=$clog2(MAX_UOPS)+1  micro-op count, 1..MAX_UOPS
instr_sels_i  in  MAX_UOPS*SEL_WIDTH  queue selector of uop k at [k*SEL_WIDTH +: SEL_WIDTH]
instr_id_o  out  ID_WIDTH  ID granted to the instruction accepted this cycle
rl_full_i  in  1  re-order logic full
trace_push_o  out  1  push one micro-op entry
trace_sel_o  out  SEL_WIDTH  queue of the pushed micro-op
trace_break_o  out  1  breakpoint flag of the pushed micro-op
trace_id_push_o  out  1  push the instruction ID; pulses with the last micro-op only
trace_id_value_o  out  ID_WIDTH  instruction ID
commit_id_valid_i  in  1  committed-ID queue is non-empty
commit_id_value_i  in  ID_WIDTH  oldest committed ID
commit_id_pull_o  out  1  pull the committed ID
retire_valid_o  out  1  registered retire strobe
retire_id_o  out  ID_WIDTH  retired ID
credits_o  out  $clog2(DEPTH)+1  free ID credits, DEPTH-outstanding
busy_o  out  1  FSM is not in IDLE
order_err_o  out  1  sticky out-of-order commit flag

Behaviour:
- Reset state: FSM=IDLE; next_id=0; exp_retire=0; outstanding=0.
- Output values during and after reset: every output is 0, except credits_o=DEPTH and instr_ready_o=1.
- ID allocation: next_id is ID_WIDTH bits and wraps DEPTH-1 -> 0.
- Credits: outstanding is 0..DEPTH.
  - +1 on each accept; -1 on each commit_id_pull_o.
  - Accept and pull in the same cycle leave outstanding unchanged.
  - Saturation must never occur; the accept gating guarantees it.
- IDLE state:
  - instr_ready_o = (outstanding < DEPTH).
  - instr_id_o = next_id combinationally.
  - On instr_valid_i & instr_ready_o: latch uop count (0 is treated as 1) and the selectors; cur_id <= next_id; next_id++; idx <= 0; go to ISSUE.
- ISSUE state:
  - instr_ready_o=0.
  - If rl_full_i=1: trace_push_o=0 and trace_id_push_o=0; idx holds; stall indefinitely.
  - Otherwise, this cycle: trace_push_o=1 and trace_sel_o=sels[idx].
  - If idx==cnt-1: trace_break_o=BREAKPOINT, trace_id_push_o=1, trace_id_value_o=cur_id, next state IDLE.
  - Otherwise: trace_break_o=~BREAKPOINT, idx++.
- Trace outputs are a combinational decode of the registered state and rl_full_i. An N-uop instruction occupies N+1 cycles minimum (accept cycle plus N issue cycles).
- Commit side:
  - commit_id_pull_o = commit_id_valid_i. Pulling occurs in any state.
  - Next cycle: retire_valid_o=1 and retire_id_o=commit_id_value_i (registered).
  - exp_retire increments, with wrap, on each pull.
- Reset mid-ISSUE: the partially issued instruction is dropped and all counters clear. The re-order logic shares the reset.

Optional Feature:
REORDER_DISPATCH_ORDER_CHECK_EN
- Defined: on each pull, if commit_id_value_i != exp_retire then order_err_o <= 1. It stays at 1 until rst_i.
- Undefined: order_err_o is tied to 0 and the compare logic is absent. exp_retire is still maintained.

Decomposition:
- Package reorder_pkg holds:
  - ID_WIDTH=$clog2(DEPTH), SEL_WIDTH=$clog2(NUM_QUEUES), UCNT_WIDTH;
  - the FSM state encoding (IDLE, ISSUE).
- Sub-module reorder_id_credit holds next_id, exp_retire, the outstanding counter, credits_o and the optional order check. The top module holds the FSM, uop latch and indexer.

Test Plan:
- Reset, then one instruction with cnt=3, sels={2,0,1}, rl_full_i=0 -> instr_id_o=0; pushes on 3 consecutive cycles with sel 1,0,2; break 0,0,1; trace_id_push_o only on the 3rd push, value 0.
- cnt=2 with rl_full_i=1 for 5 cycles after accept -> no push for 5 cycles; then 2 pushes; busy_o=1 throughout.
- 8 single-uop instructions, no commits -> IDs 0..7; credits_o reaches 0; instr_ready_o=0; the 9th is accepted only in the cycle after the first commit pull.
- 10 instructions with commits of IDs 0..9 mod 8 -> IDs wrap 7->0; retire_id_o sequence 0..7,0,1, each one cycle after its pull; order_err_o=0.
- With REORDER_DISPATCH_ORDER_CHECK_EN: commit ID 1 presented while exp_retire=0 -> order_err_o=1 next cycle and held until rst_i.
- Assert rst_i during the 2nd uop of a cnt=4 instruction -> next cycle all outputs 0, credits_o=8, next accepted ID=0.
